// File: rtl/arm_shifter_pkg.sv
// Shared types and constants for the ARM addressing-mode-1 shifter operand unit.
package arm_shifter_pkg;

    localparam int MAX_SHIFT = 32;

    // Instruction-level shift-type field encodings (bits [6:5]).
    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef enum logic [2:0] {
        OP_LSL,
        OP_LSR,
        OP_ASR,
        OP_ROR,
        OP_RRX
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/shifter_operand_decode.sv
// Combinational decode of the shifter_operand field into an iterative shift job:
// operation, working value, step count, initial carry and a forced-zero-carry flag.
module shifter_operand_decode
    import arm_shifter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              imm_flag,
    input  logic [11:0]       shifter_operand,
    input  logic [DATA_W-1:0] rm_value,
    input  logic [DATA_W-1:0] rs_value,
    input  logic              carryFlag,
    output shift_op_e         op,
    output logic [DATA_W-1:0] W,
    output logic [5:0]        N,
    output logic              C0,
    output logic              force_zero_carry
);

    localparam logic [5:0] MAX_N = 6'(MAX_SHIFT);

    logic [1:0] shift_type;
    logic [4:0] imm_amount;
    logic [7:0] rs_amount;

    assign shift_type = shifter_operand[6:5];
    assign imm_amount = shifter_operand[11:7];
    assign rs_amount  = rs_value[7:0];

    // Defaults describe LSL #0 (pass Rm, keep C), which also covers the
    // register-shift-by-zero case and the multiply/extension encoding space.
    always_comb begin
        op               = OP_LSL;
        W                = rm_value;
        N                = '0;
        C0               = carryFlag;
        force_zero_carry = 1'b0;

        if (imm_flag) begin
            op = OP_ROR;
            W  = {{(DATA_W-8){1'b0}}, shifter_operand[7:0]};
            N  = {1'b0, shifter_operand[11:8], 1'b0};
        end else if (!shifter_operand[4]) begin
            case (shift_type)
                LSL: begin
                    op = OP_LSL;
                    N  = {1'b0, imm_amount};
                end
                LSR: begin
                    op = OP_LSR;
                    N  = (imm_amount == 5'd0) ? MAX_N : {1'b0, imm_amount};
                end
                ASR: begin
                    op = OP_ASR;
                    N  = (imm_amount == 5'd0) ? MAX_N : {1'b0, imm_amount};
                end
                default: begin
                    if (imm_amount == 5'd0) begin
                        op = OP_RRX;
                        N  = 6'd1;
                    end else begin
                        op = OP_ROR;
                        N  = {1'b0, imm_amount};
                    end
                end
            endcase
        end else if (!shifter_operand[7] && rs_amount != 8'd0) begin
            case (shift_type)
                LSL, LSR: begin
                    op = (shift_type == LSL) ? OP_LSL : OP_LSR;
                    if (rs_amount > 8'd32) begin
                        N                = MAX_N;
                        force_zero_carry = 1'b1;
                    end else begin
                        N = rs_amount[5:0];
                    end
                end
                ASR: begin
                    op = OP_ASR;
                    N  = (rs_amount >= 8'd32) ? MAX_N : rs_amount[5:0];
                end
                default: begin
                    op = OP_ROR;
                    if (rs_amount[4:0] == 5'd0) begin
                        N  = '0;
                        C0 = rm_value[DATA_W-1];
                    end else begin
                        N = {1'b0, rs_amount[4:0]};
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/arm_shifter_operand_unit.sv
// Iterative ARM shifter operand unit: captures a decoded shift job on start and
// performs one bit position per clock, then pulses done with Y and carryOut.
module arm_shifter_operand_unit
    import arm_shifter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              imm_flag,
    input  logic [11:0]       shifter_operand,
    input  logic [DATA_W-1:0] rm_value,
    input  logic [DATA_W-1:0] rs_value,
    input  logic              carryFlag,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Y,
    output logic              carryOut
);

    state_e            state;
    shift_op_e         op_q;
    shift_op_e         dec_op;
    logic [DATA_W-1:0] w_q;
    logic [DATA_W-1:0] dec_w;
    logic [DATA_W-1:0] step_w;
    logic [5:0]        count;
    logic [5:0]        dec_n;
    logic              carry_q;
    logic              fz_q;
    logic              dec_c0;
    logic              dec_fz;
    logic              step_c;

    shifter_operand_decode #(.DATA_W(DATA_W)) u_decode (
        .imm_flag         (imm_flag),
        .shifter_operand  (shifter_operand),
        .rm_value         (rm_value),
        .rs_value         (rs_value),
        .carryFlag        (carryFlag),
        .op               (dec_op),
        .W                (dec_w),
        .N                (dec_n),
        .C0               (dec_c0),
        .force_zero_carry (dec_fz)
    );

    // One-bit step; the carry always takes the bit that leaves the word.
    always_comb begin
        step_w = w_q;
        step_c = carry_q;
        case (op_q)
            OP_LSL: begin
                step_w = {w_q[DATA_W-2:0], 1'b0};
                step_c = w_q[DATA_W-1];
            end
            OP_LSR: begin
                step_w = {1'b0, w_q[DATA_W-1:1]};
                step_c = w_q[0];
            end
            OP_ASR: begin
                step_w = {w_q[DATA_W-1], w_q[DATA_W-1:1]};
                step_c = w_q[0];
            end
            OP_ROR: begin
                step_w = {w_q[0], w_q[DATA_W-1:1]};
                step_c = w_q[0];
            end
            OP_RRX: begin
                step_w = {carry_q, w_q[DATA_W-1:1]};
                step_c = w_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_LSL;
            w_q      <= '0;
            count    <= '0;
            carry_q  <= 1'b0;
            fz_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Y        <= '0;
            carryOut <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q    <= dec_op;
                        w_q     <= dec_w;
                        count   <= dec_n;
                        carry_q <= dec_c0;
                        fz_q    <= dec_fz;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count != 6'd0) begin
                        w_q     <= step_w;
                        carry_q <= step_c;
                        count   <= count - 6'd1;
                    end else begin
                        Y        <= w_q;
                        carryOut <= fz_q ? 1'b0 : carry_q;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_shifter_operand_unit.sv
// Self-checking bench for arm_shifter_operand_unit: directed cases, randomized
// operations against an architectural shifter model, handshake and reset abort.
module tb_arm_shifter_operand_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        imm_flag = 1'b0;
    logic [11:0] shifter_operand = '0;
    logic [31:0] rm_value = '0;
    logic [31:0] rs_value = '0;
    logic        carryFlag = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] Y;
    logic        carryOut;

    int checks = 0;
    int failures = 0;

    localparam int TIMEOUT = 80;

    arm_shifter_operand_unit #(.DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .imm_flag        (imm_flag),
        .shifter_operand (shifter_operand),
        .rm_value        (rm_value),
        .rs_value        (rs_value),
        .carryFlag       (carryFlag),
        .busy            (busy),
        .done            (done),
        .Y               (Y),
        .carryOut        (carryOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] v, input int s);
        if (s % 32 == 0) return v;
        return (v >> (s % 32)) | (v << (32 - (s % 32)));
    endfunction

    // Architectural meaning of addressing mode 1; n is the expected step count.
    function automatic void ref_model(input logic imm, input logic [11:0] so,
                                      input logic [31:0] rm, input logic [31:0] rs,
                                      input logic c, output logic [31:0] y,
                                      output logic co, output int n);
        int a;
        int r;
        int s;
        logic [1:0] t;
        t = so[6:5];
        if (imm) begin
            a = 2 * int'(so[11:8]);
            n = a;
            y = rotr({24'd0, so[7:0]}, a);
            co = (a == 0) ? c : y[31];
        end else if (!so[4]) begin
            a = int'(so[11:7]);
            case (t)
                2'd0: begin
                    n = a;
                    if (a == 0) begin y = rm; co = c; end
                    else begin y = rm << a; co = rm[32 - a]; end
                end
                2'd1: begin
                    if (a == 0) begin n = 32; y = 0; co = rm[31]; end
                    else begin n = a; y = rm >> a; co = rm[a - 1]; end
                end
                2'd2: begin
                    if (a == 0) begin n = 32; y = {32{rm[31]}}; co = rm[31]; end
                    else begin n = a; y = 32'($signed(rm) >>> a); co = rm[a - 1]; end
                end
                default: begin
                    if (a == 0) begin n = 1; y = {c, rm[31:1]}; co = rm[0]; end
                    else begin n = a; y = rotr(rm, a); co = rm[a - 1]; end
                end
            endcase
        end else begin
            r = int'(rs[7:0]);
            if (so[7] || r == 0) begin
                n = 0; y = rm; co = c;
            end else begin
                case (t)
                    2'd0: begin
                        n = (r > 32) ? 32 : r;
                        if (r < 32) begin y = rm << r; co = rm[32 - r]; end
                        else if (r == 32) begin y = 0; co = rm[0]; end
                        else begin y = 0; co = 1'b0; end
                    end
                    2'd1: begin
                        n = (r > 32) ? 32 : r;
                        if (r < 32) begin y = rm >> r; co = rm[r - 1]; end
                        else if (r == 32) begin y = 0; co = rm[31]; end
                        else begin y = 0; co = 1'b0; end
                    end
                    2'd2: begin
                        if (r < 32) begin n = r; y = 32'($signed(rm) >>> r); co = rm[r - 1]; end
                        else begin n = 32; y = {32{rm[31]}}; co = rm[31]; end
                    end
                    default: begin
                        s = r % 32;
                        n = s;
                        if (s == 0) begin y = rm; co = rm[31]; end
                        else begin y = rotr(rm, s); co = rm[s - 1]; end
                    end
                endcase
            end
        end
    endfunction

    // Issues one request and returns the result plus the number of edges from
    // the accepting edge to the edge that raised done (TIMEOUT if none).
    task automatic applyStimulus(input logic imm, input logic [11:0] so,
                                 input logic [31:0] rm, input logic [31:0] rs,
                                 input logic c, output logic [31:0] y,
                                 output logic co, output int cycles);
        @(negedge clk);
        imm_flag = imm;
        shifter_operand = so;
        rm_value = rm;
        rs_value = rs;
        carryFlag = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = TIMEOUT;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = i;
                break;
            end
        end
        y = Y;
        co = carryOut;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++;
        if (Y !== 32'd0) begin failures++; $display("[TB] FAIL reset_Y got %h want 0", Y); end
        checks++;
        if (carryOut !== 1'b0) begin failures++; $display("[TB] FAIL reset_carry got %b want 0", carryOut); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        imm;
        logic [11:0] so;
        logic [31:0] rm;
        logic [31:0] rs;
        logic        c;
        logic [31:0] y;
        logic        co;
        int          cyc;
    } dir_case_t;

    task automatic test_directed();
        dir_case_t cases[7];
        logic [31:0] y;
        logic co;
        int cyc;
        cases[0] = '{1'b1, 12'h4FF, 32'h12345678, 32'd0, 1'b0, 32'hFF000000, 1'b1, 9};
        cases[1] = '{1'b1, 12'h0AB, 32'h12345678, 32'd0, 1'b1, 32'h000000AB, 1'b1, 1};
        cases[2] = '{1'b0, 12'h040, 32'h80000001, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 33};
        cases[3] = '{1'b0, 12'h060, 32'h00000003, 32'd0, 1'b1, 32'h80000001, 1'b1, 2};
        cases[4] = '{1'b0, 12'h010, 32'h00000001, 32'd32, 1'b0, 32'h00000000, 1'b1, 33};
        cases[5] = '{1'b0, 12'h010, 32'h00000001, 32'd33, 1'b1, 32'h00000000, 1'b0, 33};
        cases[6] = '{1'b0, 12'h070, 32'h00000001, 32'd64, 1'b1, 32'h00000001, 1'b0, 1};
        foreach (cases[i]) begin
            applyStimulus(cases[i].imm, cases[i].so, cases[i].rm, cases[i].rs, cases[i].c, y, co, cyc);
            checks++;
            if (y !== cases[i].y) begin
                failures++;
                $display("[TB] FAIL directed%0d_Y got %h want %h", i, y, cases[i].y);
            end
            checks++;
            if (co !== cases[i].co) begin
                failures++;
                $display("[TB] FAIL directed%0d_carry got %b want %b", i, co, cases[i].co);
            end
            checks++;
            if (cyc !== cases[i].cyc) begin
                failures++;
                $display("[TB] FAIL directed%0d_latency got %0d want %0d", i, cyc, cases[i].cyc);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (Y !== 32'h00000001 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_result got Y=%h busy=%b want Y=00000001 busy=0", Y, busy);
        end
    endtask

    task automatic test_random();
        logic imm;
        logic [11:0] so;
        logic [31:0] rm;
        logic [31:0] rs;
        logic c;
        logic [31:0] y;
        logic [31:0] ey;
        logic co;
        logic eco;
        int cyc;
        int en;
        for (int i = 0; i < 150; i++) begin
            imm = 1'($urandom_range(0, 2) == 0);
            so = 12'($urandom);
            rm = $urandom;
            rs = $urandom;
            if ($urandom_range(0, 1) == 1) rs[7:0] = 8'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) rs[7:0] = 8'(32 * $urandom_range(1, 7));
            c = 1'($urandom);
            ref_model(imm, so, rm, rs, c, ey, eco, en);
            applyStimulus(imm, so, rm, rs, c, y, co, cyc);
            checks++;
            if (y !== ey || co !== eco || cyc !== en + 1) begin
                failures++;
                $display("[TB] FAIL random%0d imm=%b so=%h rm=%h rs=%h c=%b got Y=%h C=%b lat=%0d want Y=%h C=%b lat=%0d",
                         i, imm, so, rm, rs, c, y, co, cyc, ey, eco, en + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int busy_low = 0;
        @(negedge clk);
        imm_flag = 1'b0;
        shifter_operand = 12'h010;
        rm_value = 32'h00000001;
        rs_value = 32'd8;
        carryFlag = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i > 0 && i < 10 && !busy) busy_low++;
            if (done) begin
                pulses++;
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses !== 1) begin failures++; $display("[TB] FAIL b2b_pulses got %0d want 1", pulses); end
        checks++;
        if (busy_low !== 0) begin failures++; $display("[TB] FAIL b2b_busy got %0d low cycles want 0", busy_low); end
        checks++;
        if (Y !== 32'h00000100 || carryOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_result got Y=%h C=%b want Y=00000100 C=0", Y, carryOut);
        end
    endtask

    task automatic test_async_reset();
        int stray = 0;
        logic [31:0] y;
        logic co;
        int cyc;
        @(negedge clk);
        imm_flag = 1'b0;
        shifter_operand = 12'h010;
        rm_value = 32'h00000001;
        rs_value = 32'd32;
        carryFlag = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Y !== 32'd0 || carryOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_outputs got busy=%b done=%b Y=%h C=%b want all 0", busy, done, Y, carryOut);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin failures++; $display("[TB] FAIL abort_no_done got %0d active cycles want 0", stray); end
        applyStimulus(1'b1, 12'h4FF, 32'd0, 32'd0, 1'b0, y, co, cyc);
        checks++;
        if (y !== 32'hFF000000 || co !== 1'b1 || cyc !== 9) begin
            failures++;
            $display("[TB] FAIL abort_recover got Y=%h C=%b lat=%0d want Y=ff000000 C=1 lat=9", y, co, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/arm_shifter_operand_unit.md
Name: arm_shifter_operand_unit

Overview:
- Multi-cycle decoder/executor for the ARM data-processing shifter_operand field (addressing mode 1).
- Takes the 12-bit operand field, I bit, Rm, Rs and C flag. Produces the 32-bit operand-2 value and the shifter carry-out.
- Sits between register-file read and the ALU, alongside the branch-offset shifter.
- Iterative: one bit position per clock, with a start/busy/done handshake.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported; the parameter exists for width declarations only.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- imm_flag  input  1  instruction bit 25 (I); 1 selects the rotated-immediate form.
- shifter_operand  input  12  instruction bits [11:0].
- rm_value  input  DATA_W  Rm contents.
- rs_value  input  DATA_W  Rs contents; only [7:0] used.
- carryFlag  input  1  current CPSR C.
- busy  output  1  high from the accepted start until done (inclusive).
- done  output  1  one-cycle pulse; Y and carryOut are valid.
- Y  output  DATA_W  shifter operand result.
- carryOut  output  1  shifter carry-out.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, Y=0, carryOut=0, count=0.
- States: IDLE, SHIFT, DONE.
- IDLE + start at edge k:
  - Capture the operands.
  - Decode into op (LSL/LSR/ASR/ROR/RRX), working value W, count N (0..32), carry C0, and a force_zero_carry flag.
  - Go to SHIFT; busy=1.
- SHIFT:
  - Each edge with count>0 performs a one-bit step and decrements count. Carry takes the bit shifted out.
  - LSL: shift left, fill with 0.
  - LSR: shift right, fill with 0.
  - ASR: shift right, fill with W[31].
  - ROR: rotate right.
  - RRX: one step only; W = {C0, W[31:1]}, carry = old W[0].
  - Edge with count==0: go to DONE. Y=W. carryOut=0 if force_zero_carry, else the running carry. done=1.
- DONE: one cycle; next edge goes to IDLE, done=0, busy=0.
- Latency: done is high in the cycle after edge k+N+1. N=0 gives done after edge k+1.
- Y and carryOut hold until the next accepted start.
- start while busy is ignored (no queueing).
- Decode, immediate form (imm_flag=1):
  - W = zero-extended imm8 = [7:0]; ROR with N = 2*[11:8].
  - N=0: carry = carryFlag.
- Decode, immediate shift (imm_flag=0, bit4=0): amount a = [11:7], type = [6:5].
  - LSL: N=a; a=0 gives carry = carryFlag.
  - LSR/ASR: a=0 encodes 32 → N=32.
  - ROR: a=0 encodes RRX, with C0 = carryFlag.
- Decode, register shift (imm_flag=0, bit4=1, bit7=0): amount r = rs_value[7:0].
  - r=0, any type: N=0, Y=Rm, carry = carryFlag.
  - LSL/LSR, 1..32: N=r.
  - LSL/LSR, r>32: N=32, force_zero_carry=1 (Y=0, C=0).
  - ASR, r≥32: N=32 (all sign bits, C=Rm[31]).
  - ROR, r[4:0]=0 with r≠0: N=0, Y=Rm, carry preset to Rm[31].
  - ROR, otherwise: N=r[4:0].
- bit4=1, bit7=1 (multiply/extension space): treated as LSL #0 (Y=Rm, C=carryFlag). Upstream never issues it.
- Running carry is initialised to C0 (carryFlag, or the preset above) at capture.
- Reset mid-operation aborts with no done pulse.

Decomposition:
- Package arm_shifter_pkg:
  - Shift-type constants: LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11.
  - Internal op encoding including RRX.
  - State encoding: IDLE, SHIFT, DONE.
  - Constant MAX_SHIFT=32.
- Sub-module shifter_operand_decode (purely combinational):
  - Inputs: imm_flag, shifter_operand, rm_value, rs_value, carryFlag.
  - Outputs: op, W, N, C0, force_zero_carry.
- Top module holds the FSM, count and the one-bit step datapath.

Test Plan:
- Immediate rotate: imm_flag=1, operand=12'h4FF, carryFlag=0 → N=8. Y=32'hFF000000, carryOut=1, done after edge k+9.
- Immediate zero rotate: imm_flag=1, operand=12'h0AB, carryFlag=1 → Y=32'h000000AB, carryOut=1, done after edge k+1.
- ASR #32 encoding: imm_flag=0, [11:7]=0, type ASR, Rm=32'h80000001 → Y=32'hFFFFFFFF, carryOut=1.
- RRX: type ROR, amount 0, Rm=32'h00000003, carryFlag=1 → Y=32'h80000001, carryOut=1, N=1.
- Register shifts, Rm=32'h00000001:
  - LSL with Rs=32 → Y=0, carryOut=1.
  - LSL with Rs=33 → Y=0, carryOut=0.
  - ROR with Rs=64 → Y=Rm, carryOut=Rm[31]=0.
- Handshake/reset:
  - start re-asserted while busy is ignored (exactly one done pulse).
  - Async reset during SHIFT → IDLE immediately, all outputs 0, no done pulse.
